// File: rtl/riscv_pipeline_ctrl_if.sv
// Hazard-controller port bundle: ID/EX/MEM hazard inputs in, stage controls out.
// slave = controller side, master = pipeline/testbench side.
interface riscv_pipeline_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             i_id_rs1;
  logic [4:0]             i_id_rs2;
  logic [1:0]             i_id_rs_used;
  logic [4:0]             i_ex_rd;
  logic                   i_ex_is_load;
  logic                   i_ex_br_taken;
  logic                   i_mem_req;
  logic                   i_dmem_ack;
  logic                   i_imem_rdy;
  logic                   o_pc_en;
  logic [3:0]             o_stage_en;
  logic [3:0]             o_stage_bubble;
  logic                   o_dmem_timeout;
  logic [STALL_CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs_used, i_ex_rd, i_ex_is_load,
           i_ex_br_taken, i_mem_req, i_dmem_ack, i_imem_rdy,
    output o_pc_en, o_stage_en, o_stage_bubble, o_dmem_timeout, o_stall_cnt
  );

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs_used, i_ex_rd, i_ex_is_load,
           i_ex_br_taken, i_mem_req, i_dmem_ack, i_imem_rdy,
    input  o_pc_en, o_stage_en, o_stage_bubble, o_dmem_timeout, o_stall_cnt
  );
endinterface

// File: rtl/riscv_pipeline_ctrl.sv
// RV32I 5-stage hazard/sequencing controller: load-use stalls, branch flushes,
// data-memory waits with timeout, and a saturating stall-cycle counter.
module riscv_pipeline_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  riscv_pipeline_ctrl_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic                   timeout_q, timeout_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       mem_stall, lu_hazard, fetch_stall;
  logic       pc_en;
  logic [3:0] stage_en, stage_bub;

  assign mem_stall   = ((state_q == MEM_WAIT) || bus.i_mem_req) && !bus.i_dmem_ack;
  assign lu_hazard   = bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
                       ((bus.i_id_rs_used[0] && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                        (bus.i_id_rs_used[1] && (bus.i_id_rs2 == bus.i_ex_rd)));
  assign fetch_stall = !bus.i_imem_rdy;

  // Priority: memory wait > branch flush > load-use > fetch stall.
  // During a memory wait only MEM/WB advances, with a bubble so WB never repeats.
  always_comb begin
    pc_en     = 1'b1;
    stage_en  = 4'b1111;
    stage_bub = 4'b0000;
    if (!i_rstn) begin
      pc_en     = 1'b0;
      stage_en  = 4'b0000;
      stage_bub = 4'b1111;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      stage_en  = 4'b1000;
      stage_bub = 4'b1000;
    end else if (bus.i_ex_br_taken) begin
      stage_bub = 4'b0011;
    end else if (lu_hazard) begin
      pc_en     = 1'b0;
      stage_en  = 4'b1110;
      stage_bub = 4'b0010;
    end else if (fetch_stall) begin
      pc_en     = 1'b0;
      stage_bub = 4'b0001;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (bus.i_mem_req && !bus.i_dmem_ack) begin
          state_d = MEM_WAIT;
          wcnt_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (wcnt_q >= TO_LAST) timeout_d = 1'b1;
        if (wcnt_q != 8'hFF)   wcnt_d    = wcnt_q + 8'd1;
        if (bus.i_dmem_ack)    state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= RUN;
      wcnt_q      <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_pc_en        = pc_en;
  assign bus.o_stage_en     = stage_en;
  assign bus.o_stage_bubble = stage_bub;
  assign bus.o_dmem_timeout = timeout_q;
  assign bus.o_stall_cnt    = stall_cnt_q;

endmodule
